// File: rtl/synch_fifo_pkg.sv
// synch_fifo_pkg: shared defaults and pointer helpers for the thresholded FIFO
package synch_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  // explicit wrap so non-power-of-two depths work
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/synch_fifo_thresh_if.sv
// synch_fifo_thresh_if: producer/consumer bus of the FIFO; master = user side, slave = FIFO side
interface synch_fifo_thresh_if import synch_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int CW = ptr_width(FIFO_DEPTH) + 1;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [CW-1:0]         fifo_counter;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, data_valid, fifo_counter, fifo_empty, fifo_full,
           almost_empty, almost_full, overflow, underflow
  );
  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, data_valid, fifo_counter, fifo_empty, fifo_full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/synch_fifo_ram.sv
// synch_fifo_ram: 1W/1R storage; registered read, or combinational read when SYNCH_FIFO_FWFT_EN is defined
module synch_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
`ifdef SYNCH_FIFO_FWFT_EN
  logic unused_ok;
  assign unused_ok = rst ^ re;
  assign rdata = mem[raddr];
`else
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
`endif
endmodule

// File: rtl/synch_fifo_thresh.sv
// synch_fifo_thresh: any-depth single-clock FIFO with threshold flags and error pulses;
// define SYNCH_FIFO_FWFT_EN for first-word-fall-through output.
module synch_fifo_thresh import synch_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input logic clk,
  input logic rst,
  synch_fifo_thresh_if.slave bus
);
  localparam int PTR_SIZE = ptr_width(FIFO_DEPTH);
  localparam int CW       = PTR_SIZE + 1;
  logic [PTR_SIZE-1:0]   wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0]         count_d, count_q;
  logic                  empty_d, empty_q, full_d, full_q;
  logic                  ae_d, ae_q, af_d, af_q;
  logic                  ovf_d, ovf_q, udf_d, udf_q;
  logic                  valid_d, valid_q;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;
  always_comb begin
    rd_ok    = bus.rd_en && !empty_q;
    wr_ok    = bus.wr_en && (!full_q || rd_ok);
    wr_ptr_d = wr_ok ? PTR_SIZE'(ptr_inc(32'(wr_ptr_q), FIFO_DEPTH)) : wr_ptr_q;
    rd_ptr_d = rd_ok ? PTR_SIZE'(ptr_inc(32'(rd_ptr_q), FIFO_DEPTH)) : rd_ptr_q;
    count_d  = (wr_ok && !rd_ok) ? count_q + 1'b1 :
               (rd_ok && !wr_ok) ? count_q - 1'b1 : count_q;
    empty_d  = count_d == '0;
    full_d   = count_d == CW'(FIFO_DEPTH);
    ae_d     = count_d <= CW'(AE_THRESH);
    af_d     = count_d >= CW'(AF_THRESH);
    ovf_d    = bus.wr_en && full_q && !rd_ok;
    udf_d    = bus.rd_en && empty_q;
`ifdef SYNCH_FIFO_FWFT_EN
    valid_d  = !empty_d;
`else
    valid_d  = rd_ok;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      valid_q  <= valid_d;
    end
  end
  synch_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .AW        (PTR_SIZE)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_ok),
    .waddr(wr_ptr_q),
    .wdata(bus.data_in),
    .re   (rd_ok),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );
  assign bus.fifo_counter = count_q;
  assign bus.fifo_empty   = empty_q;
  assign bus.fifo_full    = full_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
  assign bus.data_valid   = valid_q;
`ifdef SYNCH_FIFO_FWFT_EN
  // head word is only meaningful while the FIFO holds data
  assign bus.data_out = valid_q ? ram_rdata : '0;
`else
  assign bus.data_out = ram_rdata;
`endif
endmodule

// File: tb/tb_synch_fifo_thresh.sv
// tb_synch_fifo_thresh: table vectors plus queue scoreboard on a 16-deep and a 12-deep FIFO
module tb_synch_fifo_thresh;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  synch_fifo_thresh_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) b16 ();
  synch_fifo_thresh_if #(.DATA_WIDTH(8), .FIFO_DEPTH(12)) b12 ();
  synch_fifo_thresh #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AF_THRESH(14), .AE_THRESH(2))
    dut16 (.clk(clk), .rst(rst), .bus(b16));
  synch_fifo_thresh #(.DATA_WIDTH(8), .FIFO_DEPTH(12), .AF_THRESH(10), .AE_THRESH(2))
    dut12 (.clk(clk), .rst(rst), .bus(b12));
  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    int         cnt;
    bit         full;
    bit         empty;
    bit         ovf;
    bit         udf;
    bit         valid;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl [6];
  int checks = 0;
  int errors = 0;
  logic [7:0] m16 [$];
  logic [7:0] e16 [$];
  logic [7:0] m12 [$];
  logic [7:0] e12 [$];
  logic [7:0] last16 = 8'h00;
  logic [7:0] last12 = 8'h00;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step16(input bit wr, input bit rd, input logic [7:0] d);
    bit rok, wok, eo, eu;
    int n;
    n   = m16.size();
    rok = rd && n > 0;
    wok = wr && (n < 16 || rok);
    eo  = wr && n == 16 && !rok;
    eu  = rd && n == 0;
    if (rok) e16.push_back(m16.pop_front());
    if (wok) m16.push_back(d);
    b16.wr_en = wr;
    b16.rd_en = rd;
    b16.data_in = d;
    @(posedge clk);
    #1;
    b16.wr_en = 1'b0;
    b16.rd_en = 1'b0;
    n = m16.size();
    chk("cnt16", b16.fifo_counter, n);
    chk("empty16", b16.fifo_empty, n == 0);
    chk("full16", b16.fifo_full, n == 16);
    chk("ae16", b16.almost_empty, n <= 2);
    chk("af16", b16.almost_full, n >= 14);
    chk("ovf16", b16.overflow, eo);
    chk("udf16", b16.underflow, eu);
    chk("valid16", b16.data_valid, rok);
    if (b16.data_valid === 1'b1 && e16.size() > 0) last16 = e16.pop_front();
    chk("dout16", b16.data_out, last16);
  endtask
  task automatic step12(input bit wr, input bit rd, input logic [7:0] d, output bit acc);
    bit rok, eo;
    int n;
    n   = m12.size();
    rok = rd && n > 0;
    acc = wr && (n < 12 || rok);
    eo  = wr && n == 12 && !rok;
    if (rok) e12.push_back(m12.pop_front());
    if (acc) m12.push_back(d);
    b12.wr_en = wr;
    b12.rd_en = rd;
    b12.data_in = d;
    @(posedge clk);
    #1;
    b12.wr_en = 1'b0;
    b12.rd_en = 1'b0;
    n = m12.size();
    chk("cnt12", b12.fifo_counter, n);
    chk("full12", b12.fifo_full, n == 12);
    chk("empty12", b12.fifo_empty, n == 0);
    chk("af12", b12.almost_full, n >= 10);
    chk("ovf12", b12.overflow, eo);
    chk("valid12", b12.data_valid, rok);
    if (b12.data_valid === 1'b1 && e12.size() > 0) last12 = e12.pop_front();
    chk("dout12", b12.data_out, last12);
  endtask
  initial begin
    int nw;
    bit w, r, acc;
    tbl[0] = '{1'b1, 1'b0, 8'hAA, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 8'h55, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 8'h00,  0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55};
    tbl[3] = '{1'b1, 1'b1, 8'h33,  1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55};
    tbl[4] = '{1'b0, 1'b1, 8'h00,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[5] = '{1'b0, 1'b0, 8'h00,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33};
    b16.wr_en = 1'b0; b16.rd_en = 1'b0; b16.data_in = 8'h00;
    b12.wr_en = 1'b0; b12.rd_en = 1'b0; b12.data_in = 8'h00;
    #50;
    chk("rst_hold_cnt", b16.fifo_counter, 0);
    chk("rst_hold_empty", b16.fifo_empty, 1);
    #50;
    rst = 1'b0;
    #1;
    chk("rst_cnt", b16.fifo_counter, 0);
    chk("rst_empty", b16.fifo_empty, 1);
    chk("rst_ae", b16.almost_empty, 1);
    chk("rst_full", b16.fifo_full, 0);
    chk("rst_af", b16.almost_full, 0);
    chk("rst_ovf", b16.overflow, 0);
    chk("rst_udf", b16.underflow, 0);
    chk("rst_valid", b16.data_valid, 0);
    chk("rst_dout", b16.data_out, 0);
    for (int i = 0; i < 16; i++) step16(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 6; i++) begin
      if (i == 2) for (int k = 0; k < 16; k++) step16(1'b0, 1'b1, 8'h00);
      step16(tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("tbl%0d_cnt", i), b16.fifo_counter, tbl[i].cnt);
      chk($sformatf("tbl%0d_full", i), b16.fifo_full, tbl[i].full);
      chk($sformatf("tbl%0d_empty", i), b16.fifo_empty, tbl[i].empty);
      chk($sformatf("tbl%0d_ovf", i), b16.overflow, tbl[i].ovf);
      chk($sformatf("tbl%0d_udf", i), b16.underflow, tbl[i].udf);
      chk($sformatf("tbl%0d_valid", i), b16.data_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_dout", i), b16.data_out, tbl[i].dout);
    end
    for (int i = 0; i < 8; i++) step16(1'b1, 1'b0, 8'(8'h80 + i));
    b16.wr_en = 1'b1;
    b16.data_in = 8'hEE;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_cnt", b16.fifo_counter, 0);
    chk("midrst_empty", b16.fifo_empty, 1);
    chk("midrst_ae", b16.almost_empty, 1);
    chk("midrst_valid", b16.data_valid, 0);
    chk("midrst_dout", b16.data_out, 0);
    b16.wr_en = 1'b0;
    m16.delete();
    e16.delete();
    last16 = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    step16(1'b0, 1'b0, 8'h00);
    step16(1'b1, 1'b0, 8'h11);
    step16(1'b0, 1'b1, 8'h00);
    chk("post_rst_read", b16.data_out, 8'h11);
    for (int i = 0; i < 12; i++) step12(1'b1, 1'b0, 8'(8'h20 + i), acc);
    step12(1'b1, 1'b0, 8'hAA, acc);
    nw = 0;
    for (int c = 0; c < 400 && !(nw >= 30 && m12.size() == 0); c++) begin
      w = nw < 30 && $urandom_range(0, 3) != 0;
      r = nw >= 30 || $urandom_range(0, 1) == 1;
      step12(w, r, 8'(8'h40 + nw), acc);
      if (acc) nw++;
    end
    chk("wr12_total", nw, 30);
    chk("drain12", m12.size(), 0);
    chk("pend12", e12.size(), 0);
    chk("pend16", e16.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/synch_fifo_thresh.md
# synch_fifo_thresh

Parametrised single-clock FIFO; successor to the team's fixed 16x8 synchronous FIFO. Adds any depth (not only powers of two), programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, a read-valid strobe and defined simultaneous read/write behaviour at full and empty. Sits between producer and consumer blocks in the same clock domain wherever rate smoothing with early back-pressure is needed.

## Interface
- DATA_WIDTH, 8, word width in bits (>=1)
- FIFO_DEPTH, 16, number of entries (>=2, any integer)
- AF_THRESH, FIFO_DEPTH-2, almost_full asserts when count >= AF_THRESH (1..FIFO_DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..FIFO_DEPTH-1)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data, sampled with wr_en
- rd_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- data_valid  out  1  data_out carries a newly popped word
- fifo_counter  out  PTR_SIZE+1  occupancy 0..FIFO_DEPTH, PTR_SIZE = $clog2(FIFO_DEPTH)
- fifo_empty / fifo_full  out  1  count==0 / count==FIFO_DEPTH
- almost_empty / almost_full  out  1  threshold flags
- overflow / underflow  out  1  one-cycle error pulses

## Operation
- Write accepted (wr_ok) when wr_en && (!fifo_full || rd_ok); stores data_in at wr_ptr, wr_ptr advances.
- Read accepted (rd_ok) when rd_en && !fifo_empty; reads at rd_ptr, rd_ptr advances.
- Full + wr_en + rd_en: both accepted, count unchanged. Empty + wr_en + rd_en: only write accepted, count 1, underflow pulses.
- Pointers wrap explicitly FIFO_DEPTH-1 -> 0 (no reliance on power-of-two rollover).
- Count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both/neither; never exceeds FIFO_DEPTH nor goes below 0.
- overflow = wr_en && fifo_full && !rd_ok (word dropped, state unchanged); underflow = rd_en && fifo_empty (data_out holds).
- Storage is not reset; contents undefined until written.

## Timing
- All outputs registered; status flags reflect post-edge count, same cycle count updates.
- Reset (asynchronous assert, release on next edge): pointers 0, fifo_counter 0, fifo_empty 1, fifo_full 0, almost_empty 1 (if AE_THRESH>=0), almost_full 0, data_out 0, data_valid 0, overflow 0, underflow 0. Reset mid-transfer discards all contents immediately.
- Standard mode: data_out and data_valid update on the edge after the rd_ok cycle (1-cycle read latency); data_valid high exactly one cycle per accepted read.
- overflow/underflow assert on the edge following the offending request, one cycle each.
- Write-to-empty: fifo_empty deasserts one cycle after the write edge; read of that word possible the following cycle.

## Configuration
- SYNCH_FIFO_FWFT_EN defined: first-word-fall-through. data_out presents the head word whenever !fifo_empty, data_valid = !fifo_empty; rd_en acknowledges and pops; head update to next word on the rd_ok edge. Write into empty FIFO visible on data_out one cycle after the write edge.
- Undefined: standard mode as in Timing. Counter and flag behaviour identical in both modes.

## Structure
- Package synch_fifo_pkg: default DATA_WIDTH/FIFO_DEPTH constants, pointer-width helper function, pointer-increment-with-wrap function.
- Sub-module synch_fifo_ram: simple dual-port array, one write port, one read port (registered read in standard mode, combinational read in FWFT).
- Top holds pointers, counter, flag and error logic.

## Test plan (DATA_WIDTH 8, FIFO_DEPTH 16, AF 14, AE 2; repeat with FIFO_DEPTH 12)
- Reset held 100 ns then released -> count 0, empty 1, almost_empty 1, all others 0.
- Write 0..15 -> count 16, full 1, almost_full from count 14; 17th write 0xAA -> overflow one cycle, count stays 16, 0xAA never read.
- Read 16 words -> data_out 0..15 in order, data_valid 16 cycles, empty after last; extra read -> underflow one cycle, data_out holds 15.
- At full, wr_en+rd_en with 0x55 -> count stays 16, no overflow; 0x55 emerges as 17th read.
- At empty, wr_en+rd_en with 0x33 -> underflow pulse, count 1, next read returns 0x33.
- Write 8 words, assert rst mid-write -> immediate count 0, empty 1; FIFO_DEPTH 12 wrap: 30 interleaved writes/reads preserve order.
